// File: rtl/draw_field.sv
// PONG playfield renderer: blanking colour, border, dashed centre net and a
// frame-synchronous goal flash on the border. Two-stage pipeline, 2 pclk latency.
module draw_field #(
    parameter int          H_ACTIVE     = 1024,
    parameter int          V_ACTIVE     = 768,
    parameter int          BORDER_W     = 1,
    parameter int          NET_X        = 511,
    parameter int          NET_W        = 1,
    parameter int          DASH_OFFSET  = 8,
    parameter int          DASH_LEN     = 51,
    parameter int          DASH_PERIOD  = 100,
    parameter int          FLASH_FRAMES = 30,
    parameter int          FLASH_PERIOD = 5,
    parameter logic [11:0] BLANK_COLOR  = 12'h333
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] vcount_in,
    input  logic [10:0] hcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [11:0] color_bg,
    input  logic [11:0] color_line,
    input  logic [11:0] color_flash,
    input  logic        net_en,
    input  logic        goal_pulse,
    output logic [10:0] vcount_out,
    output logic [10:0] hcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [11:0] rgb_out,
    output logic        flash_active
);
    localparam int DW = (DASH_PERIOD > 1) ? $clog2(DASH_PERIOD) : 1;
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int PW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

    localparam logic [10:0]   BORDER_LO  = 11'(BORDER_W);
    localparam logic [10:0]   BORDER_V   = 11'(V_ACTIVE - BORDER_W);
    localparam logic [10:0]   BORDER_H   = 11'(H_ACTIVE - BORDER_W);
    localparam logic [10:0]   NET_LO     = 11'(NET_X);
    localparam logic [10:0]   NET_HI     = 11'(NET_X + NET_W);
    localparam logic [10:0]   DASH_START = 11'(DASH_OFFSET);
    localparam logic [DW-1:0] DASH_LAST  = DW'(DASH_PERIOD - 1);
    localparam logic [DW-1:0] DASH_ON    = DW'(DASH_LEN);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_FRAMES - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(FLASH_PERIOD - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLASH = 1'b1;

    logic          vblnk_prev_r;
    logic          hblnk_prev_r;
    logic [DW-1:0] dash_row_r;
    logic          goal_pending_r;
    logic [0:0]    state_r;
    logic [FW-1:0] frame_cnt_r;
    logic [PW-1:0] phase_cnt_r;
    logic          phase_r;

    logic [10:0] vcount_s1_r, hcount_s1_r;
    logic        vsync_s1_r, vblnk_s1_r, hsync_s1_r, hblnk_s1_r;
    logic        blank_s1_r, border_s1_r, net_s1_r;
    logic [11:0] color_bg_s1_r, color_line_s1_r, color_flash_s1_r;

    logic        frame_boundary_s;
    logic        goal_any_s;
    logic        border_s;
    logic        net_s;
    logic [11:0] border_col_s;

    assign frame_boundary_s = vblnk_in & ~vblnk_prev_r;
    assign goal_any_s       = goal_pending_r | goal_pulse;

    assign border_s = (vcount_in < BORDER_LO) || (vcount_in >= BORDER_V) ||
                      (hcount_in < BORDER_LO) || (hcount_in >= BORDER_H);

    assign net_s = net_en && (hcount_in >= NET_LO) && (hcount_in < NET_HI) &&
                   (vcount_in >= DASH_START) && (dash_row_r < DASH_ON);

    assign border_col_s = (flash_active && phase_r) ? color_flash_s1_r : color_line_s1_r;

    // Edge-detect history and the per-line dash counter, restarted every vertical blank.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vblnk_prev_r <= 1'b0;
            hblnk_prev_r <= 1'b0;
            dash_row_r   <= '0;
        end else begin
            vblnk_prev_r <= vblnk_in;
            hblnk_prev_r <= hblnk_in;
            if (vblnk_in) begin
                dash_row_r <= '0;
            end else if (hblnk_in && !hblnk_prev_r && (vcount_in >= DASH_START)) begin
                dash_row_r <= (dash_row_r == DASH_LAST) ? '0 : dash_row_r + 1'b1;
            end else begin
                dash_row_r <= dash_row_r;
            end
        end
    end

    // A goal is remembered until the next frame boundary consumes it.
    always_ff @(posedge pclk) begin
        if (rst) begin
            goal_pending_r <= 1'b0;
        end else if (frame_boundary_s) begin
            goal_pending_r <= 1'b0;
        end else if (goal_pulse) begin
            goal_pending_r <= 1'b1;
        end else begin
            goal_pending_r <= goal_pending_r;
        end
    end

    // Flash FSM: only ever changes at a frame boundary so no frame is split.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            flash_active <= 1'b0;
            frame_cnt_r  <= '0;
            phase_cnt_r  <= '0;
            phase_r      <= 1'b0;
        end else if (frame_boundary_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (goal_any_s) begin
                        state_r      <= ST_FLASH;
                        flash_active <= 1'b1;
                        frame_cnt_r  <= '0;
                        phase_cnt_r  <= '0;
                        phase_r      <= 1'b1;
                    end else begin
                        state_r      <= ST_IDLE;
                        flash_active <= 1'b0;
                    end
                end
                ST_FLASH: begin
                    if (goal_any_s) begin
                        frame_cnt_r <= '0;
                        phase_cnt_r <= '0;
                        phase_r     <= 1'b1;
                    end else if (frame_cnt_r == FRAME_LAST) begin
                        state_r      <= ST_IDLE;
                        flash_active <= 1'b0;
                        phase_r      <= 1'b0;
                    end else begin
                        frame_cnt_r <= frame_cnt_r + 1'b1;
                        if (phase_cnt_r == PHASE_LAST) begin
                            phase_cnt_r <= '0;
                            phase_r     <= ~phase_r;
                        end else begin
                            phase_cnt_r <= phase_cnt_r + 1'b1;
                        end
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    flash_active <= 1'b0;
                    phase_r      <= 1'b0;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    // Stage 1: timing, region flags and the pixel's colours.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vcount_s1_r      <= '0;
            hcount_s1_r      <= '0;
            vsync_s1_r       <= 1'b0;
            vblnk_s1_r       <= 1'b0;
            hsync_s1_r       <= 1'b0;
            hblnk_s1_r       <= 1'b0;
            blank_s1_r       <= 1'b0;
            border_s1_r      <= 1'b0;
            net_s1_r         <= 1'b0;
            color_bg_s1_r    <= '0;
            color_line_s1_r  <= '0;
            color_flash_s1_r <= '0;
        end else begin
            vcount_s1_r      <= vcount_in;
            hcount_s1_r      <= hcount_in;
            vsync_s1_r       <= vsync_in;
            vblnk_s1_r       <= vblnk_in;
            hsync_s1_r       <= hsync_in;
            hblnk_s1_r       <= hblnk_in;
            blank_s1_r       <= hblnk_in | vblnk_in;
            border_s1_r      <= border_s;
            net_s1_r         <= net_s;
            color_bg_s1_r    <= color_bg;
            color_line_s1_r  <= color_line;
            color_flash_s1_r <= color_flash;
        end
    end

    // Stage 2: priority colour mux and aligned timing outputs.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vcount_out <= '0;
            hcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            vcount_out <= vcount_s1_r;
            hcount_out <= hcount_s1_r;
            vsync_out  <= vsync_s1_r;
            vblnk_out  <= vblnk_s1_r;
            hsync_out  <= hsync_s1_r;
            hblnk_out  <= hblnk_s1_r;
            if (blank_s1_r) begin
                rgb_out <= BLANK_COLOR;
            end else if (border_s1_r) begin
                rgb_out <= border_col_s;
            end else if (net_s1_r) begin
                rgb_out <= color_line_s1_r;
            end else begin
                rgb_out <= color_bg_s1_r;
            end
        end
    end
endmodule

// File: tb/tb_draw_field.sv
// Bench for draw_field: sparse-pixel frames driven against a frame-level model,
// checked every cycle, plus literal pixel and flash-length expectations.
module tb_draw_field;
    localparam int HA = 1024, VA = 768, BW = 1, NX = 511, NW = 1;
    localparam int DOFF = 8, DLEN = 51, DPER = 100, FFR = 30, FPER = 5;

    logic        pclk = 1'b0;
    logic        rst;
    logic [10:0] vcount_in, hcount_in;
    logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
    logic [11:0] color_bg, color_line, color_flash;
    logic        net_en, goal_pulse;
    logic [10:0] vcount_out, hcount_out;
    logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
    logic [11:0] rgb_out;
    logic        flash_active;

    always #5 pclk = ~pclk;

    draw_field dut (
        .pclk(pclk), .rst(rst),
        .vcount_in(vcount_in), .hcount_in(hcount_in),
        .vsync_in(vsync_in), .vblnk_in(vblnk_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .color_bg(color_bg), .color_line(color_line), .color_flash(color_flash),
        .net_en(net_en), .goal_pulse(goal_pulse),
        .vcount_out(vcount_out), .hcount_out(hcount_out),
        .vsync_out(vsync_out), .vblnk_out(vblnk_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .rgb_out(rgb_out), .flash_active(flash_active)
    );

    typedef struct packed {
        logic [10:0] v;
        logic [10:0] h;
        logic        vs, vb, hs, hb;
        logic [11:0] rgb;
    } exp_t;

    exp_t exp_cur, exp_d1, exp_d2;
    logic fa_cur, fa_d1;
    int   nvec = 0, nerr = 0;
    bit   chk_en = 1'b0;
    bit   blank_chk = 1'b0;
    int   lit_n = 0;
    int   lit_h [0:11];
    int   lit_v [0:11];
    logic [11:0] lit_c [0:11];

    // model state: frame-level view of the playfield
    int m_dash = 0, m_fidx = 0;
    bit m_flash = 1'b0, m_pend = 1'b0, m_vbp = 1'b0, m_hbp = 1'b0;

    task automatic report(input string name, input logic [63:0] got, input logic [63:0] want);
        nerr++;
        if (nerr <= 40) $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    endtask

    // Latency model: what the pixel fed now must look like two clocks later.
    always @(posedge pclk) begin
        if (rst) begin
            exp_d1 <= '0;
            exp_d2 <= '0;
            fa_d1  <= 1'b0;
        end else begin
            exp_d1 <= exp_cur;
            exp_d2 <= exp_d1;
            fa_d1  <= fa_cur;
        end
    end

    always @(negedge pclk) begin
        if (chk_en) begin
            nvec++;
            if ({vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out, rgb_out} !== exp_d2)
                report("pixel", 64'({vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out, rgb_out}),
                       64'(exp_d2));
            nvec++;
            if (flash_active !== fa_d1) report("flash_active", 64'(flash_active), 64'(fa_d1));
            if (blank_chk && (hblnk_out || vblnk_out)) begin
                nvec++;
                if (rgb_out !== 12'h333) report("blank_color", 64'(rgb_out), 64'h333);
            end
            for (int i = 0; i < lit_n; i++) begin
                if (!hblnk_out && !vblnk_out && int'(hcount_out) == lit_h[i] && int'(vcount_out) == lit_v[i]) begin
                    nvec++;
                    if (rgb_out !== lit_c[i]) report($sformatf("lit(%0d,%0d)", lit_h[i], lit_v[i]), 64'(rgb_out), 64'(lit_c[i]));
                end
            end
        end
    end

    task automatic step(input logic [10:0] v, input logic [10:0] h, input logic vs, input logic vb,
                        input logic hs, input logic hb, input logic g);
        bit border, net, blank;
        logic [11:0] bcol, rgb;
        vcount_in = v; hcount_in = h; vsync_in = vs; vblnk_in = vb;
        hsync_in = hs; hblnk_in = hb; goal_pulse = g;
        if (rst) begin
            m_dash = 0; m_fidx = 0; m_flash = 1'b0; m_pend = 1'b0; m_vbp = 1'b0; m_hbp = 1'b0;
            exp_cur = '0;
            fa_cur = 1'b0;
        end else begin
            blank  = hb || vb;
            border = (int'(v) < BW) || (int'(v) >= VA - BW) || (int'(h) < BW) || (int'(h) >= HA - BW);
            net    = net_en && (int'(h) >= NX) && (int'(h) < NX + NW) && (int'(v) >= DOFF) && (m_dash < DLEN);
            bcol   = (m_flash && ((m_fidx / FPER) % 2 == 0)) ? color_flash : color_line;
            rgb    = blank ? 12'h333 : border ? bcol : net ? color_line : color_bg;
            exp_cur = '{v: v, h: h, vs: vs, vb: vb, hs: hs, hb: hb, rgb: rgb};
            if (vb) m_dash = 0;
            else if (hb && !m_hbp && int'(v) >= DOFF) m_dash = (m_dash + 1) % DPER;
            m_hbp = hb;
            if (vb && !m_vbp) begin
                if (m_pend || g) begin
                    m_flash = 1'b1;
                    m_fidx  = 0;
                end else if (m_flash) begin
                    if (m_fidx == FFR - 1) m_flash = 1'b0;
                    else m_fidx++;
                end
                m_pend = 1'b0;
            end else if (g) begin
                m_pend = 1'b1;
            end
            m_vbp = vb;
            fa_cur = m_flash;
        end
        @(posedge pclk);
        #1;
    endtask

    // Full frames carry every active line; short frames only lines 0-2 and 765-767.
    task automatic drive_frame(input bit full, input int goal_line, input bit goal_vb);
        int hs_l [0:7] = '{0, 1, 500, 510, 511, 512, 1022, 1023};
        int sl [0:5] = '{0, 1, 2, 765, 766, 767};
        int nl, v;
        nl = full ? VA : 6;
        for (int li = 0; li < nl; li++) begin
            v = full ? li : sl[li];
            for (int hi = 0; hi < 8; hi++)
                step(11'(v), 11'(hs_l[hi]), 1'b0, 1'b0, 1'b0, 1'b0, (v == goal_line) && (hi == 2));
            step(11'(v), 11'd1024, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            step(11'(v), 11'd1025, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        for (int vv = 768; vv < 772; vv++) begin
            for (int k = 0; k < 10; k++)
                step(11'(vv), (k < 8) ? 11'(hs_l[k]) : 11'(1016 + k), vv == 769, 1'b1,
                     k == 9, k >= 8, goal_vb && (vv == 768) && (k == 0));
        end
    endtask

    task automatic set_lit(input int i, input int h, input int v, input logic [11:0] c);
        lit_h[i] = h; lit_v[i] = v; lit_c[i] = c;
    endtask

    task automatic expect_lit(input string name, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) report(name, got, want);
    endtask

    initial begin
        int cnt;
        bit dropped;
        rst = 1'b1;
        color_bg = 12'hABC; color_line = 12'h123; color_flash = 12'h456;
        net_en = 1'b1;
        #1;
        step(11'd555, 11'd77, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_en = 1'b1;
        step(11'd9, 11'd511, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(11'd300, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_lit("reset_outputs",
                   64'({vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out, rgb_out, flash_active}),
                   64'h0);
        rst = 1'b0;
        color_bg = 12'h000; color_line = 12'hFFF; color_flash = 12'hF00;

        // full frame, net on
        set_lit(0, 511, 8, 12'hFFF);   set_lit(1, 511, 58, 12'hFFF);
        set_lit(2, 0, 300, 12'hFFF);   set_lit(3, 1023, 300, 12'hFFF);
        set_lit(4, 500, 0, 12'hFFF);   set_lit(5, 500, 767, 12'hFFF);
        set_lit(6, 511, 59, 12'h000);  set_lit(7, 511, 107, 12'h000);
        set_lit(8, 511, 7, 12'h000);   set_lit(9, 510, 300, 12'h000);
        set_lit(10, 511, 108, 12'hFFF); set_lit(11, 511, 758, 12'hFFF);
        lit_n = 12; blank_chk = 1'b1;
        drive_frame(1'b1, -1, 1'b0);

        // full frame, net off
        net_en = 1'b0;
        set_lit(0, 511, 8, 12'h000);  set_lit(1, 0, 300, 12'hFFF);
        set_lit(2, 500, 0, 12'hFFF);  set_lit(3, 1023, 300, 12'hFFF);
        lit_n = 4;
        drive_frame(1'b1, -1, 1'b0);
        lit_n = 0;
        net_en = 1'b1;

        // goal mid-frame, then count flashing frames
        drive_frame(1'b0, 1, 1'b0);
        set_lit(0, 500, 0, 12'hF00);   set_lit(1, 0, 1, 12'hF00);
        set_lit(2, 1023, 766, 12'hF00); set_lit(3, 511, 2, 12'h000);
        set_lit(4, 511, 765, 12'hFFF);
        lit_n = 5;
        cnt = 0;
        for (int f = 1; f <= 35; f++) begin
            if (f == 2) lit_n = 0;
            if (f == 6) begin
                set_lit(0, 500, 0, 12'hFFF); lit_n = 1;
            end
            if (f == 7) lit_n = 0;
            cnt += int'(flash_active);
            drive_frame(1'b0, -1, 1'b0);
        end
        expect_lit("flash_frames", 64'(cnt), 64'd30);

        // retrigger during frame 20 of a flash
        drive_frame(1'b0, 1, 1'b0);
        cnt = 0; dropped = 1'b0;
        for (int f = 1; f <= 55; f++) begin
            cnt += int'(flash_active);
            if (f <= 50 && !flash_active) dropped = 1'b1;
            drive_frame(1'b0, (f == 20) ? 1 : -1, 1'b0);
        end
        expect_lit("retrigger_frames", 64'(cnt), 64'd50);
        expect_lit("retrigger_no_drop", 64'(dropped), 64'd0);

        // goal coincident with vblank rise, then reset mid-flash with a goal pending
        drive_frame(1'b0, -1, 1'b1);
        expect_lit("goal_at_boundary", 64'(flash_active), 64'd1);
        drive_frame(1'b0, -1, 1'b0);
        drive_frame(1'b0, -1, 1'b0);
        step(11'd1, 11'd500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        repeat (3) step(11'd1, 11'd501, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        expect_lit("reset_clears_flash", 64'(flash_active), 64'd0);
        cnt = 0;
        for (int f = 0; f < 3; f++) begin
            drive_frame(1'b0, -1, 1'b0);
            cnt += int'(flash_active);
        end
        expect_lit("no_flash_after_reset", 64'(cnt), 64'd0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/draw_field.md
Name: draw_field

Overview:
- Parametrised playfield renderer for the PONG video pipeline.
- Sits directly after the timing generator and before the ball/paddle overlay stages.
- Draws:
  - blanking colour;
  - configurable-thickness border;
  - dashed centre net with configurable geometry.
- Adds a frame-synchronous "goal flash" animation: after a goal, the border toggles between the line colour and the flash colour for a set number of frames.

Parameters:
- H_ACTIVE, 1024, active pixels per line
- V_ACTIVE, 768, active lines per frame
- BORDER_W, 1, border thickness in pixels/lines (>=1)
- NET_X, 511, first column of centre net
- NET_W, 1, net width in pixels (>=1)
- DASH_OFFSET, 8, first line of first dash
- DASH_LEN, 51, lines per dash (< DASH_PERIOD)
- DASH_PERIOD, 100, lines per dash+gap cycle (>=2)
- FLASH_FRAMES, 30, frames the flash animation lasts (>=1)
- FLASH_PERIOD, 5, frames per flash phase before toggle (>=1)
- BLANK_COLOR, 12'h333, rgb during blanking

Ports:
- pclk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- vcount_in  in  11  vertical counter
- hcount_in  in  11  horizontal counter
- vsync_in  in  1  vertical sync
- vblnk_in  in  1  vertical blank
- hsync_in  in  1  horizontal sync
- hblnk_in  in  1  horizontal blank
- color_bg  in  12  interior fill colour
- color_line  in  12  border/net colour
- color_flash  in  12  alternate border colour during flash
- net_en  in  1  1 = draw net
- goal_pulse  in  1  single-cycle goal event, any time
- vcount_out  out  11  vcount delayed 2 cycles
- hcount_out  out  11  hcount delayed 2 cycles
- vsync_out  out  1  delayed 2 cycles
- vblnk_out  out  1  delayed 2 cycles
- hsync_out  out  1  delayed 2 cycles
- hblnk_out  out  1  delayed 2 cycles
- rgb_out  out  12  pixel colour, aligned with delayed timing
- flash_active  out  1  1 while the FLASH state is active

Behaviour:
- Reset: rst synchronous, active-high; clock pclk. All outputs, pipeline registers, counters and flags are cleared to 0; FSM goes to IDLE.
- Latency:
  - exactly 2 pclk from inputs to all timing outputs and rgb_out;
  - all timing outputs are delayed identically.
- Stage 1 registers the timing inputs plus the region flags blank, border and net. Stage 2 registers the colour mux.
- Border: active pixel with any of:
  - vcount < BORDER_W
  - vcount >= V_ACTIVE-BORDER_W
  - hcount < BORDER_W
  - hcount >= H_ACTIVE-BORDER_W
- Dash counter dash_row (width ceil(log2 DASH_PERIOD)):
  - held at 0 while vblnk_in = 1;
  - increments on each hblnk_in rising edge whose vcount_in >= DASH_OFFSET;
  - wraps DASH_PERIOD-1 -> 0.
  - Result with defaults: dashes on lines 8..58, 108..158, … 708..758.
- Net: net_en=1 AND NET_X <= hcount < NET_X+NET_W AND vcount >= DASH_OFFSET AND dash_row < DASH_LEN. net_en is sampled per pixel.
- Colour priority:
  1. blank (hblnk|vblnk) -> BLANK_COLOR
  2. border -> border_col
  3. net -> color_line
  4. else color_bg
- border_col = color_flash when flash_active=1 and phase=1; otherwise color_line.
- Frame boundary: cycle where vblnk_in rises (0 -> 1), detected with a registered copy of vblnk_in.
- goal_pending: set by goal_pulse in any cycle; cleared at the next frame boundary when it is consumed.
- FSM IDLE:
  - frame boundary with goal_pending (or goal_pulse in that same cycle) -> FLASH;
  - on entry: frame_cnt=0, phase_cnt=0, phase=1.
- FSM FLASH:
  - at each frame boundary, frame_cnt++ and phase_cnt++;
  - when phase_cnt reaches FLASH_PERIOD-1, it wraps to 0 and phase toggles;
  - at the boundary where frame_cnt == FLASH_FRAMES-1 -> IDLE, phase=0.
- Retrigger: a goal during FLASH restarts at the next boundary (frame_cnt=0, phase=1, stays in FLASH). Retrigger takes precedence over the exit.
- All FSM and colour-state changes occur only at frame boundaries, so a frame is never split.
- flash_active is registered, asserted during frames where state = FLASH, and updates on the cycle after the boundary.
- Reset mid-flash: returns to IDLE and discards goal_pending.

Test Plan:
- Reset with any inputs -> all outputs 0, flash_active=0; 2 cycles after rst release, outputs track inputs delayed by 2.
- Full frame, defaults, net_en=1, color_bg=000, color_line=FFF -> FFF at (h,v) = (511,8), (511,58), (0,300), (1023,300), (500,0), (500,767); 000 at (511,59), (511,107), (511,7), (510,300); 333 during blanking.
- net_en=0 -> (511,8) = color_bg; border unchanged.
- goal_pulse mid-frame, color_flash=F00:
  - the next frame's border = F00, net still FFF;
  - border alternates every 5 frames;
  - flash_active high for exactly 30 frames, then border = FFF.
- Second goal_pulse at frame 20 of a flash -> 30 further frames of flash from the next boundary; flash_active never drops.
- goal_pulse in the same cycle as a vblnk rise -> FLASH entered at that boundary; rst asserted during FLASH -> IDLE, no flash after release.
